// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Wide enough to count down from the largest legal read latency (7).
    localparam int CNT_W = 3;

    // Byte address is usable when word-aligned and inside the storage array.
    function automatic logic addr_ok(input logic [63:0] byte_addr,
                                     input int unsigned depth_words);
        return (byte_addr[1:0] == 2'b00) &&
               ((byte_addr >> 2) < {32'd0, depth_words});
    endfunction

    // Full-width word index; callers truncate only after addr_ok passes.
    function automatic logic [63:0] word_of(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control path and the memory responder.
// Latency: n/a (wiring only).
// Backpressure: busy=1 means requests are dropped, not queued.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (output req, wr, addr, wdata, input rdata, ready, busy, err);
    modport slave  (input req, wr, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read, no reset on contents.
// Latency: write commits at the edge, read data appears one edge after raddr.
// Backpressure: none; accepts a write and a read every cycle.
module mem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata_q
);
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Write port and registered read port share the clock.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata_q <= r_mem[i_raddr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder answering fetch/load/store strobes from the control unit.
// Latency: reads READ_LATENCY edges after accept, writes and errors 1 edge / immediate RESP.
// Backpressure: busy during READ_WAIT/WRITE; requests seen then are silently dropped.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_addr_ok;
    logic [IDX_W-1:0]  w_idx_in;
    logic [IDX_W-1:0]  w_raddr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_q;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    assign w_accept  = bus.req && ((r_state == IDLE) || (r_state == RESP));
    assign w_addr_ok = addr_ok(64'(bus.addr), DEPTH_WORDS);
    assign w_idx_in  = IDX_W'(word_of(64'(bus.addr)));

    // Point the array at the incoming address on accept so a latency-1 read
    // already has its data registered by the next edge.
    assign w_raddr = w_accept ? w_idx_in : r_idx;

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock     (clock),
        .i_we      (r_state == WRITE),
        .i_waddr   (r_idx),
        .i_wdata   (r_wdata),
        .i_raddr   (w_raddr),
        .o_rdata_q (w_rdata_q)
    );

    // State register; reset aborts any access, including an uncommitted write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept from IDLE/RESP, count down reads, writes take one edge.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, RESP: begin
                if (!bus.req) begin
                    w_next = IDLE;
                end else if (!w_addr_ok) begin
                    w_next = RESP;
                end else if (bus.wr == OP_WRITE) begin
                    w_next = WRITE;
                end else begin
                    w_next = READ_WAIT;
                end
            end
            READ_WAIT: w_next = (r_cnt == '0) ? RESP : READ_WAIT;
            WRITE:     w_next = RESP;
            default:   w_next = IDLE;
        endcase
    end

    // Request latching, latency counter and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_err   <= !w_addr_ok;
            r_cnt   <= CNT_INIT;
            r_wdata <= bus.wdata;
            if (w_addr_ok) begin
                r_idx <= w_idx_in;
            end
        end else if (r_state == READ_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_rdata <= w_rdata_q;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = (r_state == RESP);
    assign bus.err   = (r_state == RESP) && r_err;
    assign bus.busy  = (r_state == READ_WAIT) || (r_state == WRITE);
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's fetch/load/store requests. It answers the control unit's memory strobes (address selected via IorD, write strobe WR).
- Holds a word-organised storage array and returns read data after a fixed, parameterised latency, with a one-cycle ready pulse.
- The default latency of 2 matches the control unit's two fetch wait states: the request is issued in the PC-fetch state, and data is valid when the FSM returns to the PC-fetch state.
- Sits between the datapath address mux and the instruction/data registers.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width.
- DEPTH_WORDS, 256: number of storage words.
- READ_LATENCY, 2: edges from request accept to response; legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  request valid; sampled on the rising edge.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  byte address; must be word-aligned.
- wdata  in  DATA_W  write data; sampled with req.
- rdata  out  DATA_W  read data; valid while ready=1 after a read, held afterwards.
- ready  out  1  one-cycle response pulse.
- busy  out  1  request in flight; new requests are ignored.
- err  out  1  error flag, asserted together with ready.

Behaviour:
- Interface decision: reset is named reset, asynchronous, active-high; clock is named clock.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; rdata = 0, ready = 0, busy = 0, err = 0; latency counter = 0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the access. A write not yet committed is dropped.
- FSM states: IDLE, READ_WAIT, WRITE, RESP.
- Accept condition: req=1 at a rising edge while in IDLE or RESP. Call this edge T0. At T0, addr, wr and wdata are latched.
- Error check at T0: addr[1:0] != 0, or addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - Next state is RESP with err=1.
  - No storage access; rdata unchanged.
- Read:
  - T0: state goes to READ_WAIT, counter = READ_LATENCY-1.
  - Each later edge: decrement the counter. The edge at which counter==0 moves the state to RESP, with rdata = mem[word index].
  - ready is therefore high in the cycle after edge T0+READ_LATENCY.
- Write:
  - T0: state goes to WRITE.
  - Edge T0+1: mem[word index] = wdata; state goes to RESP.
  - Write latency is always 1, independent of READ_LATENCY.
- RESP:
  - ready=1 for exactly one cycle; err=1 only for a rejected request.
  - At the next edge: if req=1, accept (back-to-back, no idle bubble); otherwise go to IDLE.
- busy = 1 in READ_WAIT and WRITE; 0 in IDLE and RESP.
- req while busy is ignored: not queued, no error raised.
- Read-after-write to the same address returns the new data, because the write commits before the later read is sampled.
- rdata holds its last read value across writes, errors and idle cycles.
- Address arithmetic: word index = addr[ADDR_W-1:2], truncated to clog2(DEPTH_WORDS) bits only after the range check passes. There is no wrap-around; out-of-range addresses are errors.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, READ_WAIT, WRITE, RESP);
  - constants OP_READ=0 and OP_WRITE=1;
  - a word-index/range-check function parameterised on DEPTH_WORDS.
- Sub-module mem_array: synchronous-write, registered-read storage with DEPTH_WORDS x DATA_W, inputs we/waddr/wdata/raddr, output rdata_q.
- mem_responder contains the FSM, latency counter, request latching and error logic.

Test Plan:
- Reset mid-read: req=1, wr=0, addr=0x10 at T0; assert reset at T0+1 -> ready, busy, err and rdata are 0 immediately; no ready pulse follows.
- Write then read: write 0xDEADBEEF to 0x0C at T0 -> ready after T0+1. Read 0x0C in the RESP cycle -> busy for 2 cycles, then ready with rdata=0xDEADBEEF exactly 2 edges after accept.
- Latency sweep: READ_LATENCY in {1, 2, 7}; read addr=0x00 preloaded with 0x12345678 -> ready 1, 2 and 7 edges after accept respectively; ready high for exactly one cycle each time.
- Errors:
  - Read addr=0x02 -> ready and err in the cycle after T0; rdata unchanged.
  - Read addr=0x400 (word 256, DEPTH=256) -> ready and err; no storage change.
- Request while busy: issue a read of 0x04, then req=1, wr=1, addr=0x08 while busy=1 -> the second request is ignored and mem[0x08] is unchanged. After ready, a back-to-back read of 0x08 in the RESP cycle returns the old value.
- Fetch-loop compatibility: drive req every 3 cycles (PC-fetch, E1, E2 pattern) with addr = 0, 4, 8, 12 -> ready coincides with each return to the PC-fetch state; rdata sequence matches the preloaded words.
